red_pitaya_hk_gpio: RTL and testbench
=====================================

RED_PITAYA_HK_GPIO -- requirements
Module: red_pitaya_hk_gpio

Interface
REQ-001 SHALL have parameter NP, default 16: number of GPIO pins, legal range 1..32.
REQ-002 SHALL have parameter DBW, default 16: debounce counter width in bits.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 SHALL have port rstn_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port gpio_i, input, NP bits: raw pin inputs, asynchronous to clk_i.
REQ-006 SHALL have port gpio_o, output, NP bits: pin output data.
REQ-007 SHALL have port gpio_dir_o, output, NP bits: per-pin output enable, 1 = output.
REQ-008 SHALL have port irq_o, output, 1 bit: level interrupt request.
REQ-009 SHALL have ports sys_addr (input, 32), sys_wdata (input, 32), sys_wen (input, 1) and sys_ren (input, 1).
REQ-010 SHALL have ports sys_rdata (output, 32), sys_err (output, 1) and sys_ack (output, 1).

Function
REQ-011 SHALL decode sys_addr[19:0] into these registers:
- 0x00 DIR (RW)
- 0x04 DOUT (RW)
- 0x08 DIN (RO, filtered)
- 0x0C RISE_EN (RW)
- 0x10 FALL_EN (RW)
- 0x14 IRQ_STS (read; write-1-to-clear)
- 0x18 DEB_LEN (RW, DBW bits)
- 0x1C DOUT_SET (write-only)
- 0x20 DOUT_CLR (write-only)
- 0x24 INFO (RO) = {23'h0, DEB flag, 2'b0, NP[5:0]}
REQ-012 SHALL assert sys_ack exactly one cycle after any cycle with sys_wen|sys_ren, and hold sys_err at 0.
REQ-013 SHALL return sys_rdata in the same cycle as sys_ack; unused upper bits and unmapped addresses read 0.
REQ-014 SHALL ignore writes to RO or unmapped addresses without error; write-only registers read 0.
REQ-015 SHALL make a register write visible on its output one cycle after the sys_wen cycle.
REQ-016 SHALL update DOUT on a DOUT_SET write as DOUT | wdata, and on a DOUT_CLR write as DOUT & ~wdata.
REQ-017 SHALL pass gpio_i through a 2-FF synchronizer per pin before any other use.
REQ-018 SHALL update a pin's filtered value only after the synchronized value has differed from it for DEB_LEN+1 consecutive cycles; DEB_LEN=0 means no extra delay.
REQ-019 SHALL restart a pin's debounce counter whenever its synchronized value equals the filtered value; DEB_LEN writes take effect on the next comparison, and counters are not reset.
REQ-020 SHALL make the total latency from gpio_i to DIN readable = 2 (sync) + DEB_LEN+1 (filter) cycles.
REQ-021 SHALL set IRQ_STS[i] one cycle after the filtered value of pin i rises with RISE_EN[i]=1, or falls with FALL_EN[i]=1.
REQ-022 SHALL keep an IRQ_STS bit sticky until it is cleared by writing 1 to that bit.
REQ-023 SHALL let set win when a W1C write and a new event hit the same bit in the same cycle.
REQ-024 SHALL drive irq_o as registered |IRQ_STS, one cycle after the status change.
REQ-025 SHALL NOT let a change of RISE_EN or FALL_EN alter existing IRQ_STS bits.
REQ-026 SHALL continue edge detection on pins with DIR=1, where the input reflects the driven pad.

Reset
REQ-027 SHALL, on rstn_i low, asynchronously clear DIR, DOUT, RISE_EN, FALL_EN, IRQ_STS, irq_o, sys_ack, sys_err, sys_rdata and all debounce counters.
REQ-028 SHALL, on rstn_i low, set DEB_LEN to 0 and load the synchronizers and filtered values with 0.
REQ-029 SHALL generate no IRQ events in the first cycle after reset release.
REQ-030 SHALL, if reset asserts mid-debounce, discard the partial count; reset release does not trigger an edge on pins held high.

Configuration
REQ-031 SHALL use the macro RP_HK_GPIO_DEBOUNCE_EN to compile the debounce filter in or out.
REQ-032 SHALL, with RP_HK_GPIO_DEBOUNCE_EN defined, include the debounce filter and return INFO[8]=1.
REQ-033 SHALL, without RP_HK_GPIO_DEBOUNCE_EN, set filtered value = synchronized value (latency 2).
REQ-034 SHALL, without RP_HK_GPIO_DEBOUNCE_EN, make DEB_LEN read 0 and ignore its writes, and return INFO[8]=0.

Structure
REQ-035 SHALL place the register offset constants and the INFO field layout in the shared housekeeping package.
REQ-036 SHALL implement one sub-module, red_pitaya_hk_debounce (sync + counter + filtered bit), instantiated NP times.

Verification
REQ-037 SHALL cover: write DOUT=0x00F0, then SET 0x000F, then CLR 0x0030 -> gpio_o reads 0x00CF, each step visible 1 cycle after its write.
REQ-038 SHALL cover: DEB_LEN=4, pin 3 high for 4 cycles then low -> DIN unchanged and IRQ_STS stays 0.
REQ-039 SHALL cover: DEB_LEN=4, pin 3 high for 5 cycles -> DIN[3]=1 at the latency in REQ-020, and irq_o rises 2 cycles later with RISE_EN[3]=1.
REQ-040 SHALL cover: FALL_EN=0x1 and RISE_EN=0, pin 0 pulses 0->1->0 with DEB_LEN=0 -> only the falling edge sets IRQ_STS=0x1.
REQ-041 SHALL cover: W1C of 0x1 in the same cycle as a new pin-0 event -> IRQ_STS stays 0x1 and irq_o stays high.
REQ-042 SHALL cover: rstn_i asserted mid-debounce with pin held high -> all outputs 0 immediately, DIN=1 after release plus the REQ-020 latency, and no IRQ set.

Source files
------------

// File: rtl/red_pitaya_hk_gpio_pkg.sv
// Shared housekeeping GPIO definitions: register offsets and the INFO word layout.
// Used by red_pitaya_hk_gpio and red_pitaya_hk_debounce.
package red_pitaya_hk_gpio_pkg;

    localparam logic [19:0] ADDR_DIR      = 20'h00;
    localparam logic [19:0] ADDR_DOUT     = 20'h04;
    localparam logic [19:0] ADDR_DIN      = 20'h08;
    localparam logic [19:0] ADDR_RISE_EN  = 20'h0C;
    localparam logic [19:0] ADDR_FALL_EN  = 20'h10;
    localparam logic [19:0] ADDR_IRQ_STS  = 20'h14;
    localparam logic [19:0] ADDR_DEB_LEN  = 20'h18;
    localparam logic [19:0] ADDR_DOUT_SET = 20'h1C;
    localparam logic [19:0] ADDR_DOUT_CLR = 20'h20;
    localparam logic [19:0] ADDR_INFO     = 20'h24;

    typedef struct packed {
        logic [22:0] rsvd_hi;
        logic        deb_en;
        logic [1:0]  rsvd_lo;
        logic [5:0]  np;
    } info_t;

    function automatic logic [31:0] info_word(input int np, input logic deb_en);
        info_t info;
        info        = '0;
        info.deb_en = deb_en;
        info.np     = 6'(np);
        return info;
    endfunction

endpackage

// File: rtl/red_pitaya_hk_debounce.sv
// One GPIO pin: 2-FF synchronizer followed by an optional debounce filter.
// The filter is compiled in only when RP_HK_GPIO_DEBOUNCE_EN is defined.
module red_pitaya_hk_debounce
    import red_pitaya_hk_gpio_pkg::*;
`ifdef RP_HK_GPIO_DEBOUNCE_EN
#(
    parameter int DBW = 16
)
`endif
(
    input  logic           clk_i,
    input  logic           rstn_i,
    input  logic           pin_i,
`ifdef RP_HK_GPIO_DEBOUNCE_EN
    input  logic [DBW-1:0] deb_len,
`endif
    output logic           filt_o
);

    logic sync_q1;
    logic sync_q2;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= pin_i;
            sync_q2 <= sync_q1;
        end
    end

`ifdef RP_HK_GPIO_DEBOUNCE_EN
    logic [DBW-1:0] cnt;
    logic           filt_q;

    // Accept a new level after it has differed for deb_len+1 consecutive cycles.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt    <= '0;
            filt_q <= 1'b0;
        end else if (sync_q2 == filt_q) begin
            cnt <= '0;
        end else if (cnt >= deb_len) begin
            filt_q <= sync_q2;
            cnt    <= '0;
        end else begin
            cnt <= cnt + DBW'(1);
        end
    end

    assign filt_o = filt_q;
`else
    assign filt_o = sync_q2;
`endif

endmodule

// File: rtl/red_pitaya_hk_gpio.sv
// Housekeeping GPIO block: direction/output registers, filtered inputs and edge IRQs.
// Define RP_HK_GPIO_DEBOUNCE_EN to include the per-pin debounce filter and DEB_LEN.
module red_pitaya_hk_gpio
    import red_pitaya_hk_gpio_pkg::*;
#(
    parameter int NP  = 16,
    parameter int DBW = 16
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic [NP-1:0] gpio_i,
    output logic [NP-1:0] gpio_o,
    output logic [NP-1:0] gpio_dir_o,
    output logic          irq_o,
    input  logic [31:0]   sys_addr,
    input  logic [31:0]   sys_wdata,
    input  logic          sys_wen,
    input  logic          sys_ren,
    output logic [31:0]   sys_rdata,
    output logic          sys_err,
    output logic          sys_ack
);

`ifdef RP_HK_GPIO_DEBOUNCE_EN
    localparam logic DEB_EN = 1'b1;
`else
    localparam logic DEB_EN = 1'b0;
`endif

    logic [NP-1:0]  dir;
    logic [NP-1:0]  dout;
    logic [NP-1:0]  rise_en;
    logic [NP-1:0]  fall_en;
    logic [NP-1:0]  irq_sts;
    logic [NP-1:0]  din;
    logic [NP-1:0]  din_d;
    logic [NP-1:0]  irq_evt;
    logic [NP-1:0]  sts_clr;
    logic [NP-1:0]  wdata_np;
    logic [DBW-1:0] deb_len;
    logic [19:0]    addr;
    logic [31:0]    rdata_nxt;
    logic           unused_bits;

    assign addr        = sys_addr[19:0];
    assign wdata_np    = sys_wdata[NP-1:0];
    assign unused_bits = ^{sys_addr[31:20], sys_wdata};

    for (genvar i = 0; i < NP; i++) begin : g_pin
`ifdef RP_HK_GPIO_DEBOUNCE_EN
        red_pitaya_hk_debounce #(.DBW(DBW)) u_deb (
            .clk_i   (clk_i),
            .rstn_i  (rstn_i),
            .pin_i   (gpio_i[i]),
            .deb_len (deb_len),
            .filt_o  (din[i])
        );
`else
        red_pitaya_hk_debounce u_deb (
            .clk_i   (clk_i),
            .rstn_i  (rstn_i),
            .pin_i   (gpio_i[i]),
            .filt_o  (din[i])
        );
`endif
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            dir     <= '0;
            dout    <= '0;
            rise_en <= '0;
            fall_en <= '0;
        end else if (sys_wen) begin
            case (addr)
                ADDR_DIR:      dir     <= wdata_np;
                ADDR_DOUT:     dout    <= wdata_np;
                ADDR_DOUT_SET: dout    <= dout | wdata_np;
                ADDR_DOUT_CLR: dout    <= dout & ~wdata_np;
                ADDR_RISE_EN:  rise_en <= wdata_np;
                ADDR_FALL_EN:  fall_en <= wdata_np;
                default: ;
            endcase
        end
    end

`ifdef RP_HK_GPIO_DEBOUNCE_EN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            deb_len <= '0;
        else if (sys_wen && addr == ADDR_DEB_LEN)
            deb_len <= sys_wdata[DBW-1:0];
    end
`else
    assign deb_len = '0;
`endif

    // A new event on a bit wins over a W1C of that bit in the same cycle.
    assign irq_evt = (din & ~din_d & rise_en) | (~din & din_d & fall_en);
    assign sts_clr = (sys_wen && addr == ADDR_IRQ_STS) ? wdata_np : '0;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            din_d   <= '0;
            irq_sts <= '0;
            irq_o   <= 1'b0;
        end else begin
            din_d   <= din;
            irq_sts <= (irq_sts & ~sts_clr) | irq_evt;
            irq_o   <= |irq_sts;
        end
    end

    always_comb begin
        rdata_nxt = '0;
        case (addr)
            ADDR_DIR:     rdata_nxt = 32'(dir);
            ADDR_DOUT:    rdata_nxt = 32'(dout);
            ADDR_DIN:     rdata_nxt = 32'(din);
            ADDR_RISE_EN: rdata_nxt = 32'(rise_en);
            ADDR_FALL_EN: rdata_nxt = 32'(fall_en);
            ADDR_IRQ_STS: rdata_nxt = 32'(irq_sts);
            ADDR_DEB_LEN: rdata_nxt = 32'(deb_len);
            ADDR_INFO:    rdata_nxt = info_word(NP, DEB_EN);
            default:      rdata_nxt = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sys_ack   <= 1'b0;
            sys_rdata <= '0;
        end else begin
            sys_ack   <= sys_wen | sys_ren;
            sys_rdata <= sys_ren ? rdata_nxt : 32'h0;
        end
    end

    assign sys_err    = 1'b0;
    assign gpio_o     = dout;
    assign gpio_dir_o = dir;

endmodule

// File: tb/tb_red_pitaya_hk_gpio.sv
// Self-checking bench for red_pitaya_hk_gpio: bus reads are scoreboarded, pin
// timing is checked against latencies that depend on RP_HK_GPIO_DEBOUNCE_EN.
module tb_red_pitaya_hk_gpio;

`ifdef RP_HK_GPIO_DEBOUNCE_EN
    localparam bit DEB_ON = 1'b1;
`else
    localparam bit DEB_ON = 1'b0;
`endif

    localparam logic [31:0] A_DIR      = 32'h00;
    localparam logic [31:0] A_DOUT     = 32'h04;
    localparam logic [31:0] A_DIN      = 32'h08;
    localparam logic [31:0] A_RISE_EN  = 32'h0C;
    localparam logic [31:0] A_FALL_EN  = 32'h10;
    localparam logic [31:0] A_IRQ_STS  = 32'h14;
    localparam logic [31:0] A_DEB_LEN  = 32'h18;
    localparam logic [31:0] A_DOUT_SET = 32'h1C;
    localparam logic [31:0] A_DOUT_CLR = 32'h20;
    localparam logic [31:0] A_INFO     = 32'h24;

    typedef struct packed {
        logic        is_read;
        logic [19:0] addr;
        logic [31:0] exp;
    } sb_entry_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] gpio;
    logic [15:0] gpio_out;
    logic [15:0] gpio_dir;
    logic        irq;
    logic [31:0] sys_addr;
    logic [31:0] sys_wdata;
    logic        sys_wen;
    logic        sys_ren;
    logic [31:0] sys_rdata;
    logic        sys_err;
    logic        sys_ack;

    sb_entry_t   exp_q[$];
    int          checks = 0;
    int          errors = 0;

    red_pitaya_hk_gpio #(.NP(16), .DBW(16)) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .gpio_i     (gpio),
        .gpio_o     (gpio_out),
        .gpio_dir_o (gpio_dir),
        .irq_o      (irq),
        .sys_addr   (sys_addr),
        .sys_wdata  (sys_wdata),
        .sys_wen    (sys_wen),
        .sys_ren    (sys_ren),
        .sys_rdata  (sys_rdata),
        .sys_err    (sys_err),
        .sys_ack    (sys_ack)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called at a negedge; the DUT samples the request on the next posedge.
    task automatic applyStimulus(input bit wr, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [31:0] exp);
        sb_entry_t ent;
        ent.is_read = !wr;
        ent.addr    = addr[19:0];
        ent.exp     = exp;
        sys_addr  = addr;
        sys_wdata = data;
        sys_wen   = wr;
        sys_ren   = !wr;
        exp_q.push_back(ent);
        @(negedge clk);
        sys_wen = 1'b0;
        sys_ren = 1'b0;
        checkOutput("ack", 32'(sys_ack), 32'h1);
    endtask

    task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, addr, data, 32'h0);
    endtask

    task automatic busRead(input logic [31:0] addr, input logic [31:0] exp);
        applyStimulus(1'b0, addr, 32'h0, exp);
    endtask

    always @(negedge clk) begin
        if (rstn && sys_ack) begin
            sb_entry_t ent;
            checkOutput("sb_nonempty", 32'(exp_q.size() != 0), 32'h1);
            if (exp_q.size() != 0) begin
                ent = exp_q.pop_front();
                checkOutput("err", 32'(sys_err), 32'h0);
                if (ent.is_read)
                    checkOutput($sformatf("rd@%0h", ent.addr), sys_rdata, ent.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;
        rstn      = 1'b0;
        gpio      = '0;
        sys_addr  = '0;
        sys_wdata = '0;
        sys_wen   = 1'b0;
        sys_ren   = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_gpio_o", 32'(gpio_out), 32'h0);
        checkOutput("rst_dir", 32'(gpio_dir), 32'h0);
        checkOutput("rst_irq", 32'(irq), 32'h0);
        checkOutput("rst_ack", 32'(sys_ack), 32'h0);
        checkOutput("rst_rdata", sys_rdata, 32'h0);
        rstn = 1'b1;
        @(negedge clk);

        // Register map basics
        busRead(A_INFO, DEB_ON ? 32'h0000_0110 : 32'h0000_0010);
        busWrite(A_DIR, 32'h0000_A5A5);
        checkOutput("dir_out", 32'(gpio_dir), 32'h0000_A5A5);
        busRead(A_DIR, 32'h0000_A5A5);
        busWrite(A_DIR, 32'hFFFF_FFFF);
        busRead(A_DIR, 32'h0000_FFFF);
        busWrite(A_DIR, 32'h0);

        busWrite(A_DOUT, 32'h0000_00F0);
        checkOutput("dout_wr", 32'(gpio_out), 32'h0000_00F0);
        busWrite(A_DOUT_SET, 32'h0000_000F);
        checkOutput("dout_set", 32'(gpio_out), 32'h0000_00FF);
        busWrite(A_DOUT_CLR, 32'h0000_0030);
        checkOutput("dout_clr", 32'(gpio_out), 32'h0000_00CF);
        busRead(A_DOUT, 32'h0000_00CF);
        busRead(A_DOUT_SET, 32'h0);
        busRead(A_DOUT_CLR, 32'h0);
        busRead(32'h0000_0040, 32'h0);
        busRead(32'h4010_0004, 32'h0000_00CF);
        busWrite(A_DIN, 32'h0000_1234);
        busRead(A_DIN, 32'h0);
        busWrite(A_INFO, 32'hFFFF_FFFF);
        busRead(A_INFO, DEB_ON ? 32'h0000_0110 : 32'h0000_0010);

        busWrite(A_DEB_LEN, 32'd4);
        busRead(A_DEB_LEN, DEB_ON ? 32'd4 : 32'd0);
        busWrite(A_RISE_EN, 32'h0000_0008);
        busRead(A_RISE_EN, 32'h0000_0008);

        // Pin 3 high for only 4 cycles: filtered away when debouncing
        gpio = 16'h0008;
        repeat (4) @(negedge clk);
        gpio = 16'h0000;
        repeat (12) @(negedge clk);
        busRead(A_DIN, 32'h0);
        busRead(A_IRQ_STS, DEB_ON ? 32'h0 : 32'h8);
        busWrite(A_IRQ_STS, 32'h0000_FFFF);
        repeat (2) @(negedge clk);
        checkOutput("irq_clr0", 32'(irq), 32'h0);
        busRead(A_IRQ_STS, 32'h0);

        // Pin 3 held high: DIN flips exactly at the expected latency
        lat  = DEB_ON ? 7 : 2;
        gpio = 16'h0008;
        repeat (lat - 1) @(negedge clk);
        busRead(A_DIN, 32'h0);
        busRead(A_DIN, 32'h8);
        checkOutput("irq_pre", 32'(irq), 32'h0);
        @(negedge clk);
        checkOutput("irq_rise", 32'(irq), 32'h1);
        busRead(A_IRQ_STS, 32'h8);
        busWrite(A_IRQ_STS, 32'h8);
        repeat (2) @(negedge clk);
        checkOutput("irq_clr1", 32'(irq), 32'h0);

        // Falling-only enable on pin 0
        busWrite(A_RISE_EN, 32'h0);
        busWrite(A_FALL_EN, 32'h1);
        busWrite(A_DEB_LEN, 32'h0);
        gpio = 16'h0000;
        repeat (10) @(negedge clk);
        busRead(A_IRQ_STS, 32'h0);
        gpio = 16'h0001;
        repeat (10) @(negedge clk);
        busRead(A_IRQ_STS, 32'h0);
        busRead(A_DIN, 32'h1);
        gpio = 16'h0000;
        repeat (10) @(negedge clk);
        busRead(A_IRQ_STS, 32'h1);
        checkOutput("irq_fall", 32'(irq), 32'h1);

        // Enable changes leave status alone
        busWrite(A_FALL_EN, 32'h0);
        busWrite(A_RISE_EN, 32'h0000_FFFF);
        busRead(A_IRQ_STS, 32'h1);
        busWrite(A_RISE_EN, 32'h0);
        busWrite(A_FALL_EN, 32'h1);

        // W1C lands in the same cycle as a new falling event on pin 0
        gpio = 16'h0001;
        repeat (10) @(negedge clk);
        busRead(A_IRQ_STS, 32'h1);
        gpio = 16'h0000;
        repeat (DEB_ON ? 3 : 2) @(negedge clk);
        busWrite(A_IRQ_STS, 32'h1);
        checkOutput("irq_w1c_a", 32'(irq), 32'h1);
        @(negedge clk);
        checkOutput("irq_w1c_b", 32'(irq), 32'h1);
        busRead(A_IRQ_STS, 32'h1);

        // Reset in the middle of a debounce window
        busWrite(A_DIR, 32'h0000_0F00);
        busWrite(A_DEB_LEN, 32'd4);
        gpio = 16'h0008;
        repeat (4) @(negedge clk);
        checkOutput("pre_gpio_o", 32'(gpio_out), 32'h0000_00CF);
        checkOutput("pre_dir", 32'(gpio_dir), 32'h0000_0F00);
        checkOutput("pre_irq", 32'(irq), 32'h1);
        rstn = 1'b0;
        #1;
        checkOutput("arst_gpio_o", 32'(gpio_out), 32'h0);
        checkOutput("arst_dir", 32'(gpio_dir), 32'h0);
        checkOutput("arst_irq", 32'(irq), 32'h0);
        checkOutput("arst_ack", 32'(sys_ack), 32'h0);
        checkOutput("arst_rdata", sys_rdata, 32'h0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        lat  = DEB_ON ? 3 : 2;
        repeat (lat - 1) @(negedge clk);
        busRead(A_DIN, 32'h0);
        busRead(A_DIN, 32'h8);
        busRead(A_IRQ_STS, 32'h0);
        checkOutput("post_irq", 32'(irq), 32'h0);
        busRead(A_DEB_LEN, 32'h0);
        busRead(A_DIR, 32'h0);

        repeat (2) @(negedge clk);
        checkOutput("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
